sdram_traffic_gen: RTL
======================

Name: sdram_traffic_gen

Overview:
- Synthesizable write/read-back traffic generator and checker for the sdram_ctrl user interface.
- Writes NUM_BURSTS bursts of a deterministic pattern from BASE_ADDR, reads the same region back, and compares every word.
- Reports done, pass, timeout, error count and first failing address.
- Used on-chip for board bring-up and in simulation benches in front of sdram_ctrl.

Parameters:
- DATA_W, 16: SDRAM data width.
- ADDR_W, 24: user address width ({bank,row,col}).
- BST_LEN_W, 10: width of burst-length fields.
- BST_LEN, 10: words per burst (1..2^BST_LEN_W-1).
- NUM_BURSTS, 4: bursts per pass (>=1).
- BASE_ADDR, 0: first burst address.
- PATTERN, 0: 0 = incrementing; 1 = inverted incrementing; 2 = index XOR SEED.
- SEED, 16'hA5C3: XOR seed for PATTERN 2, truncated or zero-extended to DATA_W.
- ERR_W, 16: error counter width.
- TIMEOUT, 4096: maximum cycles without an ack while in WR or RD.

Ports:
- sdram_clk  in  1  clock
- sdram_rst_n  in  1  asynchronous active-low reset
- init_end  in  1  controller initialisation complete
- start  in  1  pulse: begin one pass; ignored unless IDLE
- sdram_wr_req  out  1  write request
- sdram_wr_bst_len  out  BST_LEN_W  constant BST_LEN
- sdram_wr_addr  out  ADDR_W  current write burst address
- sdram_wr_data  out  DATA_W  current write word
- sdram_wr_ack  in  1  controller consumed sdram_wr_data this cycle
- sdram_rd_req  out  1  read request
- sdram_rd_bst_len  out  BST_LEN_W  constant BST_LEN
- sdram_rd_addr  out  ADDR_W  current read burst address
- sdram_rd_ack  in  1  sdram_rd_data valid this cycle
- sdram_rd_data  in  DATA_W  read word
- busy  out  1  pass in progress
- done  out  1  pass finished (sticky until next start)
- pass  out  1  done with err_cnt==0 and no timeout
- timeout  out  1  watchdog expired
- err_cnt  out  ERR_W  saturating mismatch count
- first_err_addr  out  ADDR_W  address of first mismatching word

Behaviour:
- Reset (async, sdram_rst_n=0): all outputs 0 except the bst_len outputs (always BST_LEN); state IDLE; all counters 0. Reset mid-pass aborts immediately; no state survives.
- FSM states: IDLE, WAIT_INIT, WR, WR_GAP, RD, RD_GAP, DONE.
- IDLE: on start go to WAIT_INIT. On entry, clear done, pass, timeout, err_cnt and first_err_addr; set busy=1; zero the burst counter b, word counter w and global index i.
- WAIT_INIT: go to WR when init_end=1. If init_end is already 1, this state lasts exactly 1 cycle.
- Address and data rules:
  - sdram_wr_addr = sdram_rd_addr = BASE_ADDR + b*BST_LEN, modulo 2^ADDR_W; wrap is allowed.
  - Write data word = f(i), where i = b*BST_LEN + w truncated to DATA_W.
  - f: PATTERN 0 -> i; PATTERN 1 -> ~i; PATTERN 2 -> i ^ SEED.
- WR:
  - sdram_wr_req=1 (registered) for the whole state.
  - sdram_wr_data=f(i) is registered and holds until an ack.
  - On a cycle with sdram_wr_ack=1: w, i advance and sdram_wr_data becomes f(i+1) on the next edge.
  - On the ack with w==BST_LEN-1: go to WR_GAP; sdram_wr_req is 0 from the next cycle.
- WR_GAP: 1 cycle, req low. Then:
  - if b < NUM_BURSTS-1: b++, w=0, back to WR;
  - else: b=0, w=0, i=0, go to RD.
- RD:
  - sdram_rd_req=1 for the whole state.
  - On each sdram_rd_ack, compare sdram_rd_data with f(i).
  - On mismatch: err_cnt++ (saturate at all-ones). If this is the first error, first_err_addr = burst address + w.
  - w, i advance on each ack. On the last ack of the burst go to RD_GAP.
- RD_GAP: 1 cycle, req low. Then next burst back to RD, or go to DONE.
- DONE: done=1, busy=0, pass=(err_cnt==0 && !timeout). Return to IDLE the next cycle. done, pass, err_cnt, timeout and first_err_addr hold until the next start.
- Watchdog: counter reset on every ack and on each state entry.
  - If it reaches TIMEOUT-1 in WR or RD: timeout=1, both reqs drop next cycle, go to DONE.
- Acks outside their state (wr_ack outside WR, rd_ack outside RD) are ignored: no counter changes, no compare.
- Simultaneous wr_ack and rd_ack: only the ack matching the current state is acted on.
- start while busy: ignored.
- sdram_wr_req and sdram_rd_req are never high together.

Test Plan:
- Defaults, PATTERN 0, ideal model with 1 ack/cycle after a 3-cycle req latency:
  - writes 0..39 to addresses 0..39 in 4 bursts of 10;
  - reads match; done=1, pass=1, err_cnt=0;
  - req low for exactly 1 cycle between bursts.
- Read model corrupts the word at address 23 (XOR 1) and at address 31 -> err_cnt=2, first_err_addr=23, pass=0.
- start while init_end=0 for 50 cycles -> no req until init_end rises. Then WR begins within 2 cycles.
- Write model withholds ack after the 5th word:
  - timeout=1 after TIMEOUT cycles; sdram_wr_req drops; done=1, pass=0.
- PATTERN 2, SEED 16'hA5C3, BASE_ADDR 24'hFFFFFA, NUM_BURSTS 1:
  - write data = i^16'hA5C3;
  - address wraps to 24'hFFFFFA, with read addr = write addr; pass=1.
- Assert sdram_rst_n low mid-RD:
  - all outputs 0 immediately, asynchronously;
  - after release, a fresh start completes with pass=1.

Source files
------------

// File: rtl/sdram_traffic_gen.sv
`default_nettype none
// ============================================================================
// Module   : sdram_traffic_gen
// Purpose  : Write/read-back pattern generator and checker for sdram_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_traffic_gen #(
    parameter int                DATA_W     = 16,
    parameter int                ADDR_W     = 24,
    parameter int                BST_LEN_W  = 10,
    parameter int                BST_LEN    = 10,
    parameter int                NUM_BURSTS = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter int                PATTERN    = 0,
    parameter int unsigned       SEED       = 32'h0000_A5C3,
    parameter int                ERR_W      = 16,
    parameter int                TIMEOUT    = 4096
) (
    input  logic                 sdram_clk,
    input  logic                 sdram_rst_n,
    input  logic                 init_end,
    input  logic                 start,
    output logic                 sdram_wr_req,
    output logic [BST_LEN_W-1:0] sdram_wr_bst_len,
    output logic [ADDR_W-1:0]    sdram_wr_addr,
    output logic [DATA_W-1:0]    sdram_wr_data,
    input  logic                 sdram_wr_ack,
    output logic                 sdram_rd_req,
    output logic [BST_LEN_W-1:0] sdram_rd_bst_len,
    output logic [ADDR_W-1:0]    sdram_rd_addr,
    input  logic                 sdram_rd_ack,
    input  logic [DATA_W-1:0]    sdram_rd_data,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 timeout,
    output logic [ERR_W-1:0]     err_cnt,
    output logic [ADDR_W-1:0]    first_err_addr
);

    localparam int B_W  = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
    localparam int WD_W = $clog2(TIMEOUT + 1);

    localparam logic [DATA_W-1:0]    C_SEED     = DATA_W'(SEED);
    localparam logic [B_W-1:0]       C_LAST_B   = B_W'(NUM_BURSTS - 1);
    localparam logic [BST_LEN_W-1:0] C_LAST_W   = BST_LEN_W'(BST_LEN - 1);
    localparam logic [ADDR_W-1:0]    C_BST_STEP = ADDR_W'(BST_LEN);
    localparam logic [WD_W-1:0]      C_WD_MAX   = WD_W'(TIMEOUT - 1);

    localparam logic [2:0] C_IDLE      = 3'd0;
    localparam logic [2:0] C_WAIT_INIT = 3'd1;
    localparam logic [2:0] C_WR        = 3'd2;
    localparam logic [2:0] C_WR_GAP    = 3'd3;
    localparam logic [2:0] C_RD        = 3'd4;
    localparam logic [2:0] C_RD_GAP    = 3'd5;
    localparam logic [2:0] C_DONE      = 3'd6;

    logic [2:0]           state_q, state_d;
    logic [B_W-1:0]       b_q, b_d;
    logic [BST_LEN_W-1:0] w_q, w_d;
    logic [DATA_W-1:0]    i_q, i_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [WD_W-1:0]      wd_q, wd_d;
    logic                 wr_req_q, wr_req_d;
    logic                 rd_req_q, rd_req_d;
    logic [DATA_W-1:0]    wr_data_q, wr_data_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 pass_q, pass_d;
    logic                 timeout_q, timeout_d;
    logic [ERR_W-1:0]     err_cnt_q, err_cnt_d;
    logic [ADDR_W-1:0]    first_err_addr_q, first_err_addr_d;

    logic                 wr_hit, rd_hit, mismatch;

    function automatic logic [DATA_W-1:0] pat(input logic [DATA_W-1:0] idx);
        case (PATTERN)
            1:       pat = ~idx;
            2:       pat = idx ^ C_SEED;
            default: pat = idx;
        endcase
    endfunction

    always_comb begin
        state_d          = state_q;
        b_d              = b_q;
        w_d              = w_q;
        i_d              = i_q;
        addr_d           = addr_q;
        wd_d             = (wd_q != C_WD_MAX) ? wd_q + WD_W'(1) : wd_q;
        busy_d           = busy_q;
        done_d           = done_q;
        pass_d           = pass_q;
        timeout_d        = timeout_q;
        err_cnt_d        = err_cnt_q;
        first_err_addr_d = first_err_addr_q;
        wr_data_d        = wr_data_q;

        // Acks only count in the state that owns them.
        wr_hit   = (state_q == C_WR) && sdram_wr_ack;
        rd_hit   = (state_q == C_RD) && sdram_rd_ack;
        mismatch = rd_hit && (sdram_rd_data != pat(i_q));

        case (state_q)
            C_IDLE: begin
                if (start) begin
                    state_d          = C_WAIT_INIT;
                    busy_d           = 1'b1;
                    done_d           = 1'b0;
                    pass_d           = 1'b0;
                    timeout_d        = 1'b0;
                    err_cnt_d        = '0;
                    first_err_addr_d = '0;
                    b_d              = '0;
                    w_d              = '0;
                    i_d              = '0;
                    addr_d           = BASE_ADDR;
                end
            end
            C_WAIT_INIT: begin
                if (init_end) begin
                    state_d = C_WR;
                end
            end
            C_WR: begin
                if (wr_hit) begin
                    w_d = w_q + BST_LEN_W'(1);
                    i_d = i_q + DATA_W'(1);
                    if (w_q == C_LAST_W) begin
                        state_d = C_WR_GAP;
                    end
                end else if (wd_q == C_WD_MAX) begin
                    timeout_d = 1'b1;
                    state_d   = C_DONE;
                end
            end
            C_WR_GAP: begin
                w_d = '0;
                if (b_q != C_LAST_B) begin
                    b_d     = b_q + B_W'(1);
                    addr_d  = addr_q + C_BST_STEP;
                    state_d = C_WR;
                end else begin
                    b_d     = '0;
                    i_d     = '0;
                    addr_d  = BASE_ADDR;
                    state_d = C_RD;
                end
            end
            C_RD: begin
                if (rd_hit) begin
                    if (mismatch) begin
                        if (err_cnt_q != '1) begin
                            err_cnt_d = err_cnt_q + ERR_W'(1);
                        end
                        // The counter saturates, so zero means no error seen yet.
                        if (err_cnt_q == '0) begin
                            first_err_addr_d = addr_q + ADDR_W'(w_q);
                        end
                    end
                    w_d = w_q + BST_LEN_W'(1);
                    i_d = i_q + DATA_W'(1);
                    if (w_q == C_LAST_W) begin
                        state_d = C_RD_GAP;
                    end
                end else if (wd_q == C_WD_MAX) begin
                    timeout_d = 1'b1;
                    state_d   = C_DONE;
                end
            end
            C_RD_GAP: begin
                w_d = '0;
                if (b_q != C_LAST_B) begin
                    b_d     = b_q + B_W'(1);
                    addr_d  = addr_q + C_BST_STEP;
                    state_d = C_RD;
                end else begin
                    state_d = C_DONE;
                end
            end
            C_DONE: begin
                state_d = C_IDLE;
            end
            default: begin
                state_d = C_IDLE;
            end
        endcase

        if ((state_d != state_q) || wr_hit || rd_hit) begin
            wd_d = '0;
        end

        if ((state_d == C_DONE) && (state_q != C_DONE)) begin
            done_d = 1'b1;
            busy_d = 1'b0;
            pass_d = (err_cnt_d == '0) && !timeout_d;
        end

        if ((state_q == C_WR) || (state_d == C_WR)) begin
            wr_data_d = pat(i_d);
        end

        wr_req_d = (state_d == C_WR);
        rd_req_d = (state_d == C_RD);
    end

    always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
        if (!sdram_rst_n) begin
            state_q          <= C_IDLE;
            b_q              <= '0;
            w_q              <= '0;
            i_q              <= '0;
            addr_q           <= '0;
            wd_q             <= '0;
            wr_req_q         <= 1'b0;
            rd_req_q         <= 1'b0;
            wr_data_q        <= '0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
            timeout_q        <= 1'b0;
            err_cnt_q        <= '0;
            first_err_addr_q <= '0;
        end else begin
            state_q          <= state_d;
            b_q              <= b_d;
            w_q              <= w_d;
            i_q              <= i_d;
            addr_q           <= addr_d;
            wd_q             <= wd_d;
            wr_req_q         <= wr_req_d;
            rd_req_q         <= rd_req_d;
            wr_data_q        <= wr_data_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
            pass_q           <= pass_d;
            timeout_q        <= timeout_d;
            err_cnt_q        <= err_cnt_d;
            first_err_addr_q <= first_err_addr_d;
        end
    end

    assign sdram_wr_req     = wr_req_q;
    assign sdram_rd_req     = rd_req_q;
    assign sdram_wr_bst_len = BST_LEN_W'(BST_LEN);
    assign sdram_rd_bst_len = BST_LEN_W'(BST_LEN);
    assign sdram_wr_addr    = addr_q;
    assign sdram_rd_addr    = addr_q;
    assign sdram_wr_data    = wr_data_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign timeout          = timeout_q;
    assign err_cnt          = err_cnt_q;
    assign first_err_addr   = first_err_addr_q;

endmodule
`default_nettype wire
